sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single-word SDRAM memory controller (CLK/Reset-launched, Done-terminated row/bank/word access) between two requesters:
  - Port A: display/frame-buffer reader, priority port.
  - Port B: game-logic reader/writer.
- Captures one request, launches the controller with a one-cycle start pulse, tracks Done through its clear-then-set sequence, and returns read data and a completion pulse to the winning port.
- Starvation guard guarantees Port B progress; a watchdog recovers from a controller that never completes.

Parameters:
- STARVE_LIMIT, 3: consecutive A grants allowed while B is pending before B is forced.
- TIMEOUT, 63: maximum cycles spent in WAIT_CLR plus WAIT_DONE before abort.
- CW, 6: watchdog counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- Reset_N  in  1  asynchronous active-low reset.
- ReqA  in  1  Port A request; held until AckA.
- WriteA  in  1  Port A, 1=write, 0=read.
- RowA  in  4  Port A row address.
- BankA  in  2  Port A bank (frame buffer).
- WDataA  in  16  Port A write data.
- AckA  out  1  one-cycle pulse: Port A request captured.
- DoneA  out  1  one-cycle pulse: Port A access complete; RData valid for reads.
- ReqB, WriteB, RowB, BankB, WDataB, AckB, DoneB: same as Port A, for Port B.
- RData  out  16  read data; shared by both ports.
- MemRow  out  4  to controller RowAddress.
- MemBank  out  2  to controller BankAddress.
- MemWrite  out  1  to controller Write.
- MemIn  out  16  to controller In.
- MemStart  out  1  to controller Reset; active-high start pulse.
- MemOut  in  16  from controller Out.
- MemDone  in  1  from controller Done.
- Timeout  out  1  one-cycle pulse: access aborted by watchdog.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (Reset_N low, asynchronous):
  - All outputs 0, RData 0.
  - State IDLE; starvation counter 0; watchdog 0; owner A.
- States: IDLE -> LAUNCH -> WAIT_CLR -> WAIT_DONE -> RESPOND -> IDLE.
- IDLE arbitration, evaluated each cycle:
  - Only ReqA: grant A.
  - Only ReqB: grant B.
  - Both requests and starve<STARVE_LIMIT: grant A, starve+1.
  - Both requests and starve==STARVE_LIMIT: grant B.
  - Any B grant clears starve to 0.
  - A grant with ReqB low leaves starve at 0.
  - On grant: latch Write/Row/Bank/WData of the winner into Mem* registers, record owner, pulse Ack<owner>, go LAUNCH.
  - Ack and Mem* are registered: both appear the cycle after Req is sampled.
- LAUNCH: MemStart=1 for exactly one cycle. Mem* remain stable from LAUNCH until the state returns to IDLE. Clear watchdog; go WAIT_CLR.
- WAIT_CLR: wait for MemDone==0, because Done from the previous access is still high. On MemDone==0 go WAIT_DONE.
- WAIT_DONE: on MemDone==1:
  - If MemWrite==0, RData<=MemOut; otherwise RData holds its value.
  - Go RESPOND.
- RESPOND: pulse Done<owner> for one cycle, then go IDLE.
  - Arbitration restarts the next cycle, so back-to-back grants are spaced at least 1 IDLE cycle apart.
- Watchdog:
  - Increments each cycle in WAIT_CLR and WAIT_DONE.
  - When it reaches TIMEOUT: pulse Timeout, leave RData unchanged, pulse no Done, return to IDLE.
  - The requester must re-request.
- Request changes after Ack are ignored; data is already latched. Req held high after Done is treated as a new request.
- AckA and AckB are never high together; DoneA and DoneB are never high together.
- Reset_N asserted mid-access: immediate return to IDLE with all outputs 0. The controller is left to finish on its own, and its next MemStart restarts it cleanly.
- MemDone is the only asynchronous-domain input, because the controller runs on negedge. Sample it on posedge directly; its half-cycle setup is guaranteed by design.

Test Plan:
- Single A read: ReqA, WriteA=0, RowA=4'h3, BankA=2'b01; controller model returns 16'hBEEF after 14 cycles. Required: AckA 1 cycle after ReqA, MemStart one cycle, MemRow=3, MemBank=1, then DoneA pulse with RData=16'hBEEF; Busy drops after RESPOND.
- Single B write: ReqB, WriteB=1, WDataB=16'h1234. Required: MemWrite=1 and MemIn=16'h1234 held from LAUNCH through RESPOND; DoneB pulse; RData unchanged.
- Starvation: ReqA and ReqB held continuously, STARVE_LIMIT=3. Required grant order A,A,A,B,A,A,A,B; AckA and AckB never overlap.
- Stale Done: MemDone still high from the prior access at LAUNCH and stays high 2 cycles before dropping. Required: the arbiter stays in WAIT_CLR and completes only on the next rising MemDone, with no early DoneA.
- Timeout: the controller model never raises MemDone after start. Required: Timeout pulse exactly TIMEOUT cycles after entering WAIT_CLR, no Done pulse, Busy=0 next cycle, and a subsequent ReqA is granted normally.
- Async reset mid-access: Reset_N low during WAIT_DONE. Required: all outputs 0 immediately, no Done pulse; after release, the first request is granted with starve=0.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
`timescale 1ns/1ps
// Two-port front end for a single-word SDRAM controller. Port A (display) has priority,
// port B (game logic) is protected by a starvation counter, and a watchdog aborts hung accesses.
module sdram_port_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 63,
  parameter int CW           = 6
) (
  input  logic        CLK,
  input  logic        Reset_N,
  input  logic        ReqA,
  input  logic        WriteA,
  input  logic [3:0]  RowA,
  input  logic [1:0]  BankA,
  input  logic [15:0] WDataA,
  output logic        AckA,
  output logic        DoneA,
  input  logic        ReqB,
  input  logic        WriteB,
  input  logic [3:0]  RowB,
  input  logic [1:0]  BankB,
  input  logic [15:0] WDataB,
  output logic        AckB,
  output logic        DoneB,
  output logic [15:0] RData,
  output logic [3:0]  MemRow,
  output logic [1:0]  MemBank,
  output logic        MemWrite,
  output logic [15:0] MemIn,
  output logic        MemStart,
  input  logic [15:0] MemOut,
  input  logic        MemDone,
  output logic        Timeout,
  output logic        Busy
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam logic [CW-1:0] WLIM = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_CLR,
    S_WAIT_DONE,
    S_RESPOND
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic          owner_b_q, owner_b_d;
  logic          ack_a_q, ack_a_d;
  logic          ack_b_q, ack_b_d;
  logic          timeout_q, timeout_d;
  logic          mem_write_q, mem_write_d;
  logic [3:0]    mem_row_q, mem_row_d;
  logic [1:0]    mem_bank_q, mem_bank_d;
  logic [15:0]   mem_in_q, mem_in_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          grant_b;

  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      wdog_q      <= '0;
      owner_b_q   <= 1'b0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      timeout_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_row_q   <= '0;
      mem_bank_q  <= '0;
      mem_in_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wdog_q      <= wdog_d;
      owner_b_q   <= owner_b_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      timeout_q   <= timeout_d;
      mem_write_q <= mem_write_d;
      mem_row_q   <= mem_row_d;
      mem_bank_q  <= mem_bank_d;
      mem_in_q    <= mem_in_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wdog_d      = wdog_q;
    owner_b_d   = owner_b_q;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    timeout_d   = 1'b0;
    mem_write_d = mem_write_q;
    mem_row_d   = mem_row_q;
    mem_bank_d  = mem_bank_q;
    mem_in_d    = mem_in_q;
    rdata_d     = rdata_q;
    grant_b     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ReqA || ReqB) begin
          // Contention only counts against B while B is actually waiting.
          if (ReqA && ReqB) begin
            if (starve_q < SLIM) begin
              grant_b  = 1'b0;
              starve_d = starve_q + 1'b1;
            end else begin
              grant_b  = 1'b1;
              starve_d = '0;
            end
          end else begin
            grant_b  = ReqB;
            starve_d = '0;
          end
          owner_b_d   = grant_b;
          ack_a_d     = !grant_b;
          ack_b_d     = grant_b;
          mem_write_d = grant_b ? WriteB : WriteA;
          mem_row_d   = grant_b ? RowB   : RowA;
          mem_bank_d  = grant_b ? BankB  : BankA;
          mem_in_d    = grant_b ? WDataB : WDataA;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wdog_d  = '0;
        state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        wdog_d = wdog_q + 1'b1;
        if (wdog_q == WLIM) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else if (!MemDone) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        wdog_d = wdog_q + 1'b1;
        // A completion seen on the last watchdog cycle still wins over the abort.
        if (MemDone) begin
          if (!mem_write_q) begin
            rdata_d = MemOut;
          end
          state_d = S_RESPOND;
        end else if (wdog_q == WLIM) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign AckA     = ack_a_q;
  assign AckB     = ack_b_q;
  assign DoneA    = (state_q == S_RESPOND) && !owner_b_q;
  assign DoneB    = (state_q == S_RESPOND) && owner_b_q;
  assign RData    = rdata_q;
  assign MemRow   = mem_row_q;
  assign MemBank  = mem_bank_q;
  assign MemWrite = mem_write_q;
  assign MemIn    = mem_in_q;
  assign MemStart = (state_q == S_LAUNCH);
  assign Timeout  = timeout_q;
  assign Busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
`timescale 1ns/1ps
// Bench for sdram_port_arbiter: a negedge controller model, a directed vector table,
// hand-written corner sequences and a randomized phase against a rule-level reference.
module tb_sdram_port_arbiter;

  localparam int STARVE_LIMIT = 3;
  localparam int TIMEOUT      = 63;

  typedef struct {
    bit          req;
    bit          wr;
    logic [3:0]  row;
    logic [1:0]  bank;
    logic [15:0] wdata;
  } preq_t;

  typedef struct {
    preq_t       a;
    preq_t       b;
    int          stale;
    int          lat;
    bit          exp_b;
    logic [15:0] exp_rdata;
  } vec_t;

  logic        CLK = 1'b0;
  logic        Reset_N = 1'b0;
  logic        ReqA = 1'b0, WriteA = 1'b0, ReqB = 1'b0, WriteB = 1'b0;
  logic [3:0]  RowA = '0, RowB = '0;
  logic [1:0]  BankA = '0, BankB = '0;
  logic [15:0] WDataA = '0, WDataB = '0;
  logic        AckA, DoneA, AckB, DoneB, MemWrite, MemStart, Timeout, Busy;
  logic [15:0] RData, MemIn;
  logic [3:0]  MemRow;
  logic [1:0]  MemBank;
  logic [15:0] MemOut = '0;
  logic        MemDone = 1'b1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  sdram_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT), .CW(6)) dut (
    .CLK(CLK), .Reset_N(Reset_N),
    .ReqA(ReqA), .WriteA(WriteA), .RowA(RowA), .BankA(BankA), .WDataA(WDataA),
    .AckA(AckA), .DoneA(DoneA),
    .ReqB(ReqB), .WriteB(WriteB), .RowB(RowB), .BankB(BankB), .WDataB(WDataB),
    .AckB(AckB), .DoneB(DoneB),
    .RData(RData), .MemRow(MemRow), .MemBank(MemBank), .MemWrite(MemWrite),
    .MemIn(MemIn), .MemStart(MemStart), .MemOut(MemOut), .MemDone(MemDone),
    .Timeout(Timeout), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // Controller model: Done stays high for cfg_stale cycles after the start pulse, drops,
  // then rises cfg_lat counts later with the word (never rises when cfg_hang is set).
  int          cfg_stale = 0;
  int          cfg_lat   = 2;
  bit          cfg_hang  = 1'b0;
  logic [15:0] ctl_mem [64];
  bit          ctl_wr  [64];
  int          ctl_cnt    = 0;
  bit          ctl_active = 1'b0;
  logic [5:0]  ctl_addr   = '0;

  function automatic logic [15:0] default_word(input logic [5:0] a);
    return (a == 6'h13) ? 16'hBEEF : (16'h5A00 | {10'd0, a});
  endfunction

  always @(negedge CLK) begin
    if (MemStart) begin
      ctl_active = 1'b1;
      ctl_cnt    = 0;
      ctl_addr   = {MemBank, MemRow};
      if (MemWrite) begin
        ctl_mem[{MemBank, MemRow}] = MemIn;
        ctl_wr[{MemBank, MemRow}]  = 1'b1;
      end
    end else if (ctl_active) begin
      ctl_cnt++;
      if (ctl_cnt > cfg_stale) MemDone = 1'b0;
      if (!cfg_hang && ctl_cnt >= cfg_stale + cfg_lat) begin
        MemDone    = 1'b1;
        MemOut     = ctl_wr[ctl_addr] ? ctl_mem[ctl_addr] : default_word(ctl_addr);
        ctl_active = 1'b0;
      end
    end
  end

  // Reference: starvation rule as a plain integer, memory as an array of words.
  int          ref_starve = 0;
  logic [15:0] ref_rdata  = '0;
  logic [15:0] ref_mem [64];
  bit          ref_wrv [64];

  function automatic logic [15:0] ref_read(input logic [5:0] a);
    return ref_wrv[a] ? ref_mem[a] : default_word(a);
  endfunction

  task automatic pick_model(input bit ra, input bit rb, output bit win_b);
    if (ra && rb) begin
      if (ref_starve < STARVE_LIMIT) begin
        ref_starve++;
        win_b = 1'b0;
      end else begin
        ref_starve = 0;
        win_b = 1'b1;
      end
    end else begin
      ref_starve = 0;
      win_b = rb;
    end
  endtask

  task automatic ref_commit(input preq_t w);
    if (w.wr) begin
      ref_mem[{w.bank, w.row}] = w.wdata;
      ref_wrv[{w.bank, w.row}] = 1'b1;
    end else begin
      ref_rdata = ref_read({w.bank, w.row});
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (AckA || AckB) check("ack_exclusive", 64'(AckA & AckB), 64'd0);
    if (DoneA || DoneB) check("done_exclusive", 64'(DoneA & DoneB), 64'd0);
  endtask

  task automatic drive(input preq_t a, input preq_t b);
    ReqA = a.req; WriteA = a.wr; RowA = a.row; BankA = a.bank; WDataA = a.wdata;
    ReqB = b.req; WriteB = b.wr; RowB = b.row; BankB = b.bank; WDataB = b.wdata;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({AckA, AckB, DoneA, DoneB, MemStart, Timeout, Busy, MemWrite,
                MemRow, MemBank, MemIn, RData});
  endfunction

  // One complete access started from IDLE; leaves the DUT idle on return.
  task automatic run_access(input preq_t a, input preq_t b, input int stale, input int lat,
                            input bit hang, output bit got_b, output bit got_to,
                            output logic [15:0] rd);
    int    n;
    int    s_l;
    int    starts;
    bit    seen;
    bit    stable_ok;
    preq_t w;
    logic [22:0] exp_mem;
    cfg_stale = stale;
    cfg_lat   = lat;
    cfg_hang  = hang;
    drive(a, b);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 8) begin
      tick();
      n++;
      seen = AckA || AckB;
    end
    check("ack_latency", 64'(n), 64'd1);
    ReqA = 1'b0;
    ReqB = 1'b0;
    got_b  = AckB;
    got_to = 1'b1;
    rd     = RData;
    if (!seen) return;
    w       = got_b ? b : a;
    exp_mem = {w.wr, w.row, w.bank, w.wdata};
    check("memstart_with_ack", 64'(MemStart), 64'd1);
    check("mem_fields", 64'({MemWrite, MemRow, MemBank, MemIn}), 64'(exp_mem));
    s_l       = cyc;
    starts    = 0;
    stable_ok = 1'b1;
    n         = 0;
    do begin
      tick();
      n++;
      if (MemStart) starts++;
      if ({MemWrite, MemRow, MemBank, MemIn} !== exp_mem) stable_ok = 1'b0;
    end while (!(DoneA || DoneB || Timeout) && n < 200);
    check("memstart_single", 64'(starts), 64'd0);
    check("mem_stable", 64'(stable_ok), 64'd1);
    got_to = Timeout;
    if (hang) begin
      check("timeout_pulse", 64'(Timeout), 64'd1);
      check("timeout_cycles", 64'(cyc - s_l), 64'(TIMEOUT + 1));
      check("timeout_no_done", 64'({DoneA, DoneB}), 64'd0);
    end else begin
      check("done_owner", 64'({DoneA, DoneB}), got_b ? 64'd1 : 64'd2);
      check("done_cycles", 64'(cyc - s_l), 64'(stale + lat + 1));
      check("busy_in_respond", 64'(Busy), 64'd1);
      check("no_timeout", 64'(Timeout), 64'd0);
    end
    rd = RData;
    tick();
    check("busy_after", 64'(Busy), 64'd0);
    check("pulses_end", 64'({DoneA, DoneB, Timeout}), 64'd0);
  endtask

  function automatic vec_t mkv(input bit ra, input bit rb, input bit wr, input logic [3:0] row,
                               input logic [1:0] bank, input logic [15:0] wd, input int stale,
                               input int lat, input bit exp_b, input logic [15:0] exp_rd);
    vec_t v;
    v.a.req = ra; v.a.wr = wr; v.a.row = row; v.a.bank = bank; v.a.wdata = wd;
    // Under contention B asks for a different word so a wrong winner shows up in the data.
    v.b.req  = rb;
    v.b.wr   = wr;
    v.b.row  = (ra && rb) ? ~row : row;
    v.b.bank = bank;
    v.b.wdata = (ra && rb) ? ~wd : wd;
    v.stale = stale; v.lat = lat; v.exp_b = exp_b; v.exp_rdata = exp_rd;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: bench still running at cycle %0d", cyc);
    $fatal(1, "bench did not terminate");
  end

  initial begin
    vec_t        vec [10];
    preq_t       pa, pb, w;
    bit          got_b, got_to, pred_b;
    bit          order [8];
    int          nacks, n, stale, lat;
    logic [15:0] rd, exp_rd;
    bit          exp_order [8];

    vec[0] = mkv(1, 0, 0, 4'h3, 2'h1, 16'h0000, 0, 14, 0, 16'hBEEF);
    vec[1] = mkv(0, 1, 1, 4'h5, 2'h2, 16'h1234, 1, 3,  1, 16'hBEEF);
    vec[2] = mkv(1, 0, 0, 4'h5, 2'h2, 16'h0000, 2, 4,  0, 16'h1234);
    vec[3] = mkv(0, 1, 0, 4'h0, 2'h0, 16'h0000, 0, 2,  1, 16'h5A00);
    vec[4] = mkv(1, 0, 1, 4'h0, 2'h0, 16'hCAFE, 3, 5,  0, 16'h5A00);
    vec[5] = mkv(0, 1, 0, 4'h0, 2'h0, 16'h0000, 0, 6,  1, 16'hCAFE);
    vec[6] = mkv(1, 1, 0, 4'h7, 2'h3, 16'h0000, 1, 2,  0, 16'h5A37);
    vec[7] = mkv(1, 1, 1, 4'h7, 2'h3, 16'h0F0F, 0, 3,  0, 16'h5A37);
    vec[8] = mkv(1, 1, 0, 4'h7, 2'h3, 16'h0000, 2, 2,  0, 16'h0F0F);
    vec[9] = mkv(1, 1, 0, 4'h7, 2'h3, 16'h0000, 0, 7,  1, 16'h5A38);
    exp_order = '{0, 0, 0, 1, 0, 0, 0, 1};

    repeat (3) tick();
    check("reset_outputs", all_outs(), 64'd0);
    Reset_N = 1'b1;
    tick();
    check("idle_after_reset", all_outs(), 64'd0);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      pick_model(vec[i].a.req, vec[i].b.req, pred_b);
      run_access(vec[i].a, vec[i].b, vec[i].stale, vec[i].lat, 1'b0, got_b, got_to, rd);
      check($sformatf("vec%0d_owner", i), 64'(got_b), 64'(vec[i].exp_b));
      check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vec[i].exp_rdata));
      check($sformatf("vec%0d_no_timeout", i), 64'(got_to), 64'd0);
      ref_commit(pred_b ? vec[i].b : vec[i].a);
    end

    // Hung controller: abort, keep RData, then a normal retry
    pa = '{1'b1, 1'b0, 4'h1, 2'h0, 16'h0};
    pb = '{1'b0, 1'b0, 4'h0, 2'h0, 16'h0};
    pick_model(1'b1, 1'b0, pred_b);
    run_access(pa, pb, 0, 2, 1'b1, got_b, got_to, rd);
    check("timeout_flag", 64'(got_to), 64'd1);
    check("timeout_rdata_kept", 64'(rd), 64'(ref_rdata));
    pick_model(1'b1, 1'b0, pred_b);
    run_access(pa, pb, 0, 5, 1'b0, got_b, got_to, rd);
    check("retry_owner", 64'(got_b), 64'd0);
    check("retry_rdata", 64'(rd), 64'h5A01);
    ref_commit(pa);

    // Starvation: a B-only grant first so the counter starts from zero
    pa.req = 1'b0;
    pb = '{1'b1, 1'b0, 4'h9, 2'h2, 16'h0};
    pick_model(1'b0, 1'b1, pred_b);
    run_access(pa, pb, 0, 2, 1'b0, got_b, got_to, rd);
    check("pre_starve_owner", 64'(got_b), 64'd1);
    ref_commit(pb);
    pa = '{1'b1, 1'b0, 4'h2, 2'h0, 16'h0};
    pb = '{1'b1, 1'b0, 4'hA, 2'h1, 16'h0};
    cfg_stale = 0;
    cfg_lat   = 2;
    drive(pa, pb);
    nacks = 0;
    n     = 0;
    while (nacks < 8 && n < 400) begin
      tick();
      n++;
      if (AckA || AckB) begin
        order[nacks] = AckB;
        nacks++;
      end
    end
    ReqA = 1'b0;
    ReqB = 1'b0;
    check("starve_ack_count", 64'(nacks), 64'd8);
    for (int k = 0; k < 8; k++) check($sformatf("starve_grant%0d", k), 64'(order[k]), 64'(exp_order[k]));
    for (int k = 0; k < 8; k++) pick_model(1'b1, 1'b1, pred_b);
    ref_commit(pb);
    n = 0;
    while ((Busy || DoneA || DoneB) && n < 100) begin
      tick();
      n++;
    end
    check("starve_idle", 64'(Busy), 64'd0);
    check("starve_rdata", 64'(RData), 64'(ref_rdata));

    // Reset in WAIT_DONE with the starvation counter at two
    for (int k = 0; k < 2; k++) begin
      pick_model(1'b1, 1'b1, pred_b);
      run_access(pa, pb, 0, 2, 1'b0, got_b, got_to, rd);
      check("prerst_owner", 64'(got_b), 64'(pred_b));
      ref_commit(pred_b ? pb : pa);
    end
    cfg_stale = 0;
    cfg_lat   = 20;
    drive(pa, pb);
    n = 0;
    while (!(AckA || AckB) && n < 8) begin
      tick();
      n++;
    end
    check("rst_access_owner", 64'({AckA, AckB}), 64'd2);
    ReqA = 1'b0;
    ReqB = 1'b0;
    repeat (4) tick();
    check("rst_in_wait", 64'({Busy, MemStart}), 64'd2);
    Reset_N = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 64'd0);
    repeat (2) begin
      tick();
      check("reset_no_done", 64'({DoneA, DoneB}), 64'd0);
    end
    Reset_N = 1'b1;
    ref_starve = 0;
    ref_rdata  = '0;
    for (int k = 0; k < 4; k++) begin
      pick_model(1'b1, 1'b1, pred_b);
      run_access(pa, pb, 1, 3, 1'b0, got_b, got_to, rd);
      check($sformatf("postrst_owner%0d", k), 64'(got_b), (k == 3) ? 64'd1 : 64'd0);
      w = pred_b ? pb : pa;
      check($sformatf("postrst_rdata%0d", k), 64'(rd), 64'(ref_read({w.bank, w.row})));
      ref_commit(w);
    end

    // Randomized traffic against the reference
    for (int it = 0; it < 40; it++) begin
      pa.req = 1'($urandom_range(0, 1));
      pb.req = 1'($urandom_range(0, 1));
      if (!pa.req && !pb.req) pb.req = 1'b1;
      pa.wr = ($urandom_range(0, 3) == 0);
      pb.wr = ($urandom_range(0, 2) == 0);
      pa.row = 4'($urandom); pa.bank = 2'($urandom); pa.wdata = 16'($urandom);
      pb.row = 4'($urandom); pb.bank = 2'($urandom); pb.wdata = 16'($urandom);
      stale = int'($urandom_range(0, 3));
      lat   = int'($urandom_range(2, 20));
      pick_model(pa.req, pb.req, pred_b);
      run_access(pa, pb, stale, lat, 1'b0, got_b, got_to, rd);
      check($sformatf("rnd%0d_owner", it), 64'(got_b), 64'(pred_b));
      w = pred_b ? pb : pa;
      exp_rd = w.wr ? ref_rdata : ref_read({w.bank, w.row});
      check($sformatf("rnd%0d_rdata", it), 64'(rd), 64'(exp_rd));
      ref_commit(w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
